// File: rtl/program_loader_mem_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_mem_pkg
// Shared types and constants for the program loader and its unified memory.
//   - Memory geometry (word address width, word width, depth)
//   - Frame limits and length-byte field masks
//   - Loader state encoding
//   - Helper that qualifies a received length byte
// -----------------------------------------------------------------------------
package program_loader_mem_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 32;
    localparam int MAX_WORDS  = 32;

    // Width of the words_loaded counter; one extra bit so MAX_WORDS fits.
    localparam int WCNT_WIDTH = ADDR_WIDTH + 1;

    // Length byte layout: [5:0] word count, [7:6] reserved and must be zero.
    localparam logic [7:0] LEN_COUNT_MASK = 8'h3F;
    localparam logic [7:0] LEN_RSVD_MASK  = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_HI   = 3'd1,
        ST_RX_LO   = 3'd2,
        ST_RX_CSUM = 3'd3,
        ST_RUN     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } loader_state_e;

    // A length byte is usable when the reserved bits are clear and the count
    // is in 1..MAX_WORDS.
    function automatic logic len_is_valid(input logic [7:0] len_byte);
        logic [7:0] count;
        count = len_byte & LEN_COUNT_MASK;
        return ((len_byte & LEN_RSVD_MASK) == 8'h00) &&
               (count != 8'd0) &&
               (count <= 8'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/program_loader_mem_unified_mem_32x16.sv
// -----------------------------------------------------------------------------
// unified_mem_32x16
// Word-addressed memory shared by instructions and data.
//   clk         : clock
//   srst        : synchronous active-high clear of every word
//   we_i        : write strobe
//   waddr_i     : write address
//   wdata_i     : write data
//   raddr_i     : read address
//   rdata_o     : mem[raddr_i], combinational (a write at edge k shows from
//                 edge k onward; no same-cycle bypass)
// The reset clear forces a flop-based implementation; a block RAM cannot be
// cleared in one cycle.
// -----------------------------------------------------------------------------
module unified_mem_32x16 #(
    parameter int ADDR_WIDTH = program_loader_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = program_loader_mem_pkg::DATA_WIDTH,
    parameter int DEPTH      = program_loader_mem_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader_mem.sv
// -----------------------------------------------------------------------------
// program_loader_mem
// Byte-stream program loader in front of a unified 32x16 memory.
// A frame is: length byte N, 2N data bytes (high byte first, written to
// words 0..N-1), then an XOR checksum of the data bytes. A good frame releases
// the core (core_reset=0, start_execution=1); afterwards the core owns the
// memory port until it halts and a new frame is sent.
//   clock, reset          : clock and synchronous active-high reset
//   rx_data/rx_valid/
//   rx_ready              : incoming byte stream (valid/ready)
//   cpu_mem_addr          : core word address (read and write)
//   cpu_mem_write_data    : core store data
//   cpu_mem_write         : core store strobe (honoured in RUN/DONE only)
//   cpu_mem_read_data     : mem[cpu_mem_addr], combinational
//   cpu_halted            : core halted flag, RUN -> DONE
//   core_reset            : reset drive to the core
//   start_execution       : run enable to the core
//   load_done             : program accepted (RUN or DONE)
//   load_error            : last frame rejected
//   words_loaded          : words written by the current/last frame
// -----------------------------------------------------------------------------
module program_loader_mem
    import program_loader_mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_write_data,
    input  logic                  cpu_mem_write,
    output logic [DATA_WIDTH-1:0] cpu_mem_read_data,
    input  logic                  cpu_halted,
    output logic                  core_reset,
    output logic                  start_execution,
    output logic                  load_done,
    output logic                  load_error,
    output logic [WCNT_WIDTH-1:0] words_loaded
);

    loader_state_e         state_q, state_d;
    logic [WCNT_WIDTH-1:0] words_q, words_d;
    logic [WCNT_WIDTH-1:0] count_q, count_d;   // N of the frame in progress
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            csum_q, csum_d;
    logic                  error_q, error_d;

    logic                  byte_acc;
    logic                  ldr_we;
    logic                  core_owns;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Control outputs are pure state decodes so they change exactly one
    // cycle after the byte that moved the state.
    assign rx_ready        = (state_q != ST_RUN);
    assign core_owns       = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign start_execution = core_owns;
    assign core_reset      = !core_owns;
    assign load_done       = core_owns;
    assign load_error      = error_q;
    assign words_loaded    = words_q;

    assign byte_acc = rx_valid && rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            count_q <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        count_d = count_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        error_d = error_q;
        ldr_we  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (byte_acc) begin
                    words_d = '0;
                    csum_d  = '0;
                    error_d = 1'b0;
                    count_d = rx_data[WCNT_WIDTH-1:0];
                    if (len_is_valid(rx_data)) begin
                        state_d = ST_RX_HI;
                    end else begin
                        // A malformed length byte rejects the whole frame.
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end

            ST_RX_HI: begin
                if (byte_acc) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_RX_LO;
                end
            end

            ST_RX_LO: begin
                if (byte_acc) begin
                    ldr_we = 1'b1;
                    csum_d = csum_q ^ rx_data;
                    if (words_q != WCNT_WIDTH'(MAX_WORDS)) begin
                        words_d = words_q + 1'b1;
                    end
                    if (WCNT_WIDTH'(words_q + 1'b1) == count_q) begin
                        state_d = ST_RX_CSUM;
                    end else begin
                        state_d = ST_RX_HI;
                    end
                end
            end

            ST_RX_CSUM: begin
                if (byte_acc) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        // Words already written stay in memory.
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (cpu_halted) begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-port ownership: loader during RX_*, core during RUN/DONE. The two
    // never write in the same cycle because ownership is decided by state.
    assign mem_we    = ldr_we || (core_owns && cpu_mem_write);
    assign mem_waddr = core_owns ? cpu_mem_addr : words_q[ADDR_WIDTH-1:0];
    assign mem_wdata = core_owns ? cpu_mem_write_data : {hi_q, rx_data};

    unified_mem_32x16 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clock),
        .srst    (reset),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (cpu_mem_addr),
        .rdata_o (cpu_mem_read_data)
    );

endmodule

// File: tb/tb_program_loader_mem.sv
// -----------------------------------------------------------------------------
// tb_program_loader_mem
// Directed frames with hand-computed expectations. Stimulus pushes expected
// observations into a queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_program_loader_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [4:0]  cpu_mem_addr;
    logic [15:0] cpu_mem_write_data;
    logic        cpu_mem_write;
    logic [15:0] cpu_mem_read_data;
    logic        cpu_halted;
    logic        core_reset;
    logic        start_execution;
    logic        load_done;
    logic        load_error;
    logic [5:0]  words_loaded;

    always #5 clock = ~clock;

    program_loader_mem dut (
        .clock              (clock),
        .reset              (reset),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .cpu_mem_addr       (cpu_mem_addr),
        .cpu_mem_write_data (cpu_mem_write_data),
        .cpu_mem_write      (cpu_mem_write),
        .cpu_mem_read_data  (cpu_mem_read_data),
        .cpu_halted         (cpu_halted),
        .core_reset         (core_reset),
        .start_execution    (start_execution),
        .load_done          (load_done),
        .load_error         (load_error),
        .words_loaded       (words_loaded)
    );

    localparam int SEL_MEM   = 0;
    localparam int SEL_RDY   = 1;
    localparam int SEL_CRST  = 2;
    localparam int SEL_START = 3;
    localparam int SEL_DONE  = 4;
    localparam int SEL_ERR   = 5;
    localparam int SEL_WL    = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: everything queued during the preceding half cycle is compared
    // here, while inputs and outputs are stable.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            chk_t        c;
            logic [15:0] act;
            c = exp_q.pop_front();
            case (c.sel)
                SEL_MEM:   act = cpu_mem_read_data;
                SEL_RDY:   act = {15'd0, rx_ready};
                SEL_CRST:  act = {15'd0, core_reset};
                SEL_START: act = {15'd0, start_execution};
                SEL_DONE:  act = {15'd0, load_done};
                SEL_ERR:   act = {15'd0, load_error};
                default:   act = {10'd0, words_loaded};
            endcase
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end else begin
                $display("ok   %s = 0x%0h", c.name, act);
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [15:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic expect_status(input string tag, input logic rdy, input logic crst,
                                 input logic start, input logic done, input logic err,
                                 input logic [5:0] wl);
        push({tag, ".rx_ready"},        SEL_RDY,   {15'd0, rdy});
        push({tag, ".core_reset"},      SEL_CRST,  {15'd0, crst});
        push({tag, ".start_execution"}, SEL_START, {15'd0, start});
        push({tag, ".load_done"},       SEL_DONE,  {15'd0, done});
        push({tag, ".load_error"},      SEL_ERR,   {15'd0, err});
        push({tag, ".words_loaded"},    SEL_WL,    {10'd0, wl});
        tick();
    endtask

    task automatic expect_mem(input string tag, input logic [4:0] a, input logic [15:0] v);
        cpu_mem_addr = a;
        push($sformatf("%s.mem[%0d]", tag, a), SEL_MEM, v);
        tick();
    endtask

    task automatic halt_core();
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
    endtask

    logic [7:0]  frame_ok [6];
    logic [15:0] big_word;
    logic [7:0]  big_csum;

    initial begin
        frame_ok[0] = 8'h02; frame_ok[1] = 8'h88; frame_ok[2] = 8'h05;
        frame_ok[3] = 8'hF8; frame_ok[4] = 8'h00; frame_ok[5] = 8'h75;

        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        cpu_mem_addr = 5'd0; cpu_mem_write_data = 16'h0; cpu_mem_write = 1'b0;
        cpu_halted = 1'b0;
        repeat (3) tick();
        expect_status("reset", 1, 1, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        expect_mem("reset", 5'd0, 16'h0000);
        expect_mem("reset", 5'd31, 16'h0000);

        // 1: good two-word frame
        send_byte(8'h02);
        expect_status("t1_len", 1, 1, 0, 0, 0, 0);
        for (int i = 1; i < 5; i++) send_byte(frame_ok[i]);
        push("t1_pre_csum.words_loaded", SEL_WL, 16'd2);
        tick();
        send_byte(frame_ok[5]);
        expect_status("t1_run", 0, 0, 1, 1, 0, 2);
        expect_mem("t1", 5'd0, 16'h8805);
        expect_mem("t1", 5'd1, 16'hF800);

        // 4: core store in RUN; bytes offered during RUN are not taken
        expect_mem("t4_before", 5'd5, 16'h0000);
        cpu_mem_addr = 5'd5; cpu_mem_write_data = 16'h1234; cpu_mem_write = 1'b1;
        tick();
        cpu_mem_write = 1'b0;
        expect_mem("t4_after", 5'd5, 16'h1234);
        rx_data = 8'h01; rx_valid = 1'b1;
        repeat (2) tick();
        rx_valid = 1'b0;
        expect_status("t4_rx_ignored", 0, 0, 1, 1, 0, 2);

        // 5: halt, then reload a one-word frame from DONE
        halt_core();
        expect_status("t5_done", 1, 0, 1, 1, 0, 2);
        send_byte(8'h01);
        expect_status("t5_len", 1, 1, 0, 0, 0, 0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h66);
        expect_status("t5_run", 0, 0, 1, 1, 0, 1);
        expect_mem("t5", 5'd0, 16'hABCD);
        expect_mem("t5_kept", 5'd1, 16'hF800);
        expect_mem("t5_kept", 5'd5, 16'h1234);
        halt_core();

        // 2: bad checksum, then retry
        for (int i = 0; i < 5; i++) send_byte(frame_ok[i]);
        send_byte(8'h74);
        expect_status("t2_err", 1, 1, 0, 0, 1, 2);
        expect_mem("t2", 5'd0, 16'h8805);
        expect_mem("t2", 5'd1, 16'hF800);
        send_byte(frame_ok[0]);
        push("t2_retry_len.load_error", SEL_ERR, 16'd0);
        tick();
        for (int i = 1; i < 6; i++) send_byte(frame_ok[i]);
        expect_status("t2_retry_run", 0, 0, 1, 1, 0, 2);
        halt_core();

        // 3: invalid length bytes
        send_byte(8'h00);
        expect_status("t3_len00", 1, 1, 0, 0, 1, 0);
        send_byte(8'h21);
        expect_status("t3_len21", 1, 1, 0, 0, 1, 0);
        send_byte(8'h41);
        expect_status("t3_len41", 1, 1, 0, 0, 1, 0);
        expect_mem("t3_nowrite", 5'd0, 16'h8805);
        expect_mem("t3_nowrite", 5'd2, 16'h0000);

        // Boundary: full 32-word frame from ERROR, with idle gaps mixed in
        big_csum = 8'h00;
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            big_word = {8'(i * 3 + 1), 8'(i) ^ 8'h5A};
            big_csum = big_csum ^ big_word[15:8] ^ big_word[7:0];
            send_byte(big_word[15:8]);
            if (i % 7 == 0) tick();
            send_byte(big_word[7:0]);
        end
        send_byte(big_csum);
        expect_status("full_run", 0, 0, 1, 1, 0, 32);
        expect_mem("full", 5'd0, 16'h015A);
        expect_mem("full", 5'd31, 16'h5E45);
        halt_core();

        // 6: reset after 3 bytes of an N=2 frame, with gaps
        send_byte(8'h02);
        tick();
        send_byte(8'h11);
        tick(); tick();
        send_byte(8'h22);
        tick();
        reset = 1'b1;
        tick();
        tick();
        expect_status("t6_reset", 1, 1, 0, 0, 0, 0);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) expect_mem("t6_clear", 5'(a), 16'h0000);

        // Let the monitor drain; a stuck queue is itself a failure.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) tick();
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader_mem.md
Name: program_loader_mem

Overview:
Unified 32x16 instruction/data memory plus byte-stream program loader, sitting directly upstream of the CPU core. It receives a framed program over a byte valid/ready stream and writes it into memory. After a good checksum it releases the core from reset and asserts start_execution. During execution it serves the core's fetches, loads and stores on a combinational-read, synchronous-write port.

Parameters:
ADDR_WIDTH, 5, memory word address width (core mem_addr width)
DATA_WIDTH, 16, memory word width (instruction/data width)
DEPTH, 32, number of words; equals 2**ADDR_WIDTH

Ports:
clock  input  1  system clock, single domain
reset  input  1  synchronous, active-high reset
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
cpu_mem_addr  input  5  core address
cpu_mem_write_data  input  16  core store data
cpu_mem_write  input  1  core store strobe
cpu_mem_read_data  output  16  mem[cpu_mem_addr], combinational
cpu_halted  input  1  core halted flag
core_reset  output  1  reset drive to core
start_execution  output  1  run enable to core
load_done  output  1  program accepted (RUN or DONE)
load_error  output  1  last frame rejected
words_loaded  output  6  words written in current/last frame

Behaviour:
- Single clock. Reset is synchronous and active-high; ports are named clock and reset.
- Reset values:
  - State IDLE; start_execution 0; core_reset 1; load_error 0; words_loaded 0.
  - rx_ready 1.
  - All memory words are 0.
- A byte is accepted when rx_valid && rx_ready at a clock edge. rx_ready is decoded from state: 1 in IDLE, RX_HI, RX_LO, RX_CSUM, DONE and ERROR; 0 in RUN. Idle cycles with rx_valid=0 have no effect in any state.
- Frame format:
  - Length byte N, using bits[5:0]; bits[7:6] must be 0.
  - Then 2N data bytes, high byte first, written to addresses 0..N-1.
  - Then one checksum byte equal to the XOR of all 2N data bytes.
- Valid N is 1..32. N=0, N>32 or nonzero bits[7:6] leads to ERROR on the cycle after acceptance.
- State machine:
  - IDLE/DONE/ERROR: on length byte, go to RX_HI (or ERROR if N is invalid). Clear words_loaded, the checksum accumulator and load_error. Load N into the word counter. Hold core_reset 1 and start_execution 0 from the next cycle.
  - RX_HI: latch the high byte, XOR it into the checksum, go to RX_LO.
  - RX_LO: write {hi, byte} to mem[words_loaded] in the same edge. XOR the byte into the checksum and increment words_loaded. Go to RX_CSUM when words_loaded+1 == N, else back to RX_HI.
  - RX_CSUM: on a match, go to RUN. On a mismatch, go to ERROR with load_error=1. Words already written are retained.
  - RUN: core_reset 0 and start_execution 1, both valid in the first RUN cycle. When cpu_halted=1, go to DONE.
  - DONE: start_execution 1 and core_reset 0 are held, so the core stays halted. A new length byte reloads as from IDLE.
  - ERROR: start_execution 0, core_reset 1.
- Memory port arbitration:
  - The loader owns the write port in RX_* states; the core owns it in RUN and DONE.
  - cpu_mem_write is ignored outside RUN/DONE. Loader writes never coincide with core writes.
- cpu_mem_read_data is always combinational mem[cpu_mem_addr]. A write at edge k is visible on read from edge k onward (no read-during-write bypass in the same cycle).
- Unloaded words (addresses >= N) keep their prior contents.
- Reset mid-frame aborts the load. All outputs return to reset values and memory is cleared.
- Addresses wrap at 5 bits; words_loaded saturates at 32.

Decomposition:
- Shared package:
  - Loader state enum (IDLE, RX_HI, RX_LO, RX_CSUM, RUN, DONE, ERROR).
  - ADDR_WIDTH, DATA_WIDTH and DEPTH constants.
  - MAX_WORDS = 32 and the length-byte field masks.
- Sub-module unified_mem_32x16:
  - Array with combinational read, single synchronous write port.
  - Synchronous clear on reset.
  - The loader instantiates it and muxes the write port by state.

Test Plan:
1. Bytes 0x02, 0x88, 0x05, 0xF8, 0x00, 0x75 -> mem[0]=0x8805, mem[1]=0xF800, words_loaded=2. Next cycle: RUN, start_execution=1, core_reset=0, load_done=1, rx_ready=0.
2. Same frame with checksum 0x74 -> ERROR, load_error=1, start_execution=0, core_reset=1. mem[0..1] still written. Retrying the correct frame clears load_error and reaches RUN.
3. Length bytes 0x00, then 0x21, then 0x41 -> ERROR after each. No memory writes; words_loaded=0.
4. In RUN, cpu_mem_write=1, cpu_mem_addr=5, data 0x1234 -> cpu_mem_read_data=0x1234 at addr 5 after the edge. rx_valid=1 during RUN is not accepted (rx_ready=0).
5. In RUN, cpu_halted=1 -> DONE. New length byte 0x01 -> core_reset=1, start_execution=0 next cycle. Load 0xAB, 0xCD, 0x66 -> mem[0]=0xABCD, RUN.
6. Reset asserted after 3 accepted bytes of an N=2 frame, with rx_valid gaps between bytes -> IDLE, all outputs at reset values, all memory words 0.
